// File: rtl/typed_dim_pkg.sv
// typed_dim_pkg
//   Shared types and helpers for the typed_dim_fifo block.
//   - clog2_safe : ceil(log2(n)) clamped to a minimum of 1, so index
//                  widths are never zero.
//   - TYPED_DIM_ELEM_T(W)       : element type, logic [W-1:0].
//   - TYPED_DIM_ENTRY_T(W, N)   : entry type, a packed array [N-1:0] of
//                                 W-bit elements; element 0 sits in the LSBs.
//   A package cannot take parameters. The typedef macros let each module
//   declare types whose dimensions follow its own parameters.
//   Optional feature macro: TYPED_DIM_FIFO_COUNT_EN (used by the top).

`ifndef TYPED_DIM_PKG_MACROS
`define TYPED_DIM_PKG_MACROS
`define TYPED_DIM_ELEM_T(W) logic [(W)-1:0]
`define TYPED_DIM_ENTRY_T(W, N) logic [(N)-1:0][(W)-1:0]
`endif

package typed_dim_pkg;

  // ceil(log2(n)), never less than 1.
  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/typed_dim_fifo_nz_reduce.sv
// typed_dim_nz_reduce
//   Purely combinational: one output bit per element of an entry, set when
//   that element is non-zero.
//   Ports:
//     i_entry : entry, ELEMS elements of ELEM_W bits, element 0 in the LSBs
//     o_nz    : ELEMS bits, o_nz[k] = |i_entry[k]

module typed_dim_nz_reduce
  import typed_dim_pkg::*;
#(
  parameter int ELEM_W = 6,
  parameter int ELEMS  = 2
) (
  input  logic [ELEMS*ELEM_W-1:0] i_entry,
  output logic [ELEMS-1:0]        o_nz
);

  typedef `TYPED_DIM_ENTRY_T(ELEM_W, ELEMS) entry_t;

  entry_t w_entry;
  assign w_entry = i_entry;

  for (genvar k = 0; k < ELEMS; k++) begin : g_elem
    assign o_nz[k] = |w_entry[k];
  end

endmodule

// File: rtl/typed_dim_fifo.sv
// typed_dim_fifo
//   Synchronous FIFO of DEPTH entries. Each entry is a packed array of ELEMS
//   elements of ELEM_W bits. The head entry is presented combinationally,
//   together with a per-element non-zero vector.
//   Handshake: a write transfers on a rising edge where in_valid && in_ready;
//   a read transfers on a rising edge where out_valid && out_ready. in_ready
//   is !full and never depends on out_ready. out_valid is !empty. Requests
//   made while full (write) or empty (read) have no effect.
//   Ports:
//     clk, rst     : clock; synchronous active-high reset
//     in_valid     : write request
//     in_ready     : not full
//     in_data      : entry to write
//     out_valid    : not empty
//     out_ready    : read acknowledge
//     out_data     : head entry, all zeros when empty
//     out_elem_nz  : per-element non-zero flags of the head, zero when empty
//     count        : occupancy, present only with TYPED_DIM_FIFO_COUNT_EN
//   Optional feature macro: TYPED_DIM_FIFO_COUNT_EN.

module typed_dim_fifo
  import typed_dim_pkg::*;
#(
  parameter int ELEM_W = 6,
  parameter int ELEMS  = 2,
  parameter int DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ELEMS*ELEM_W-1:0]             in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ELEMS*ELEM_W-1:0]             out_data,
  output logic [ELEMS-1:0]                    out_elem_nz
`ifdef TYPED_DIM_FIFO_COUNT_EN
  ,
  output logic [typed_dim_pkg::clog2_safe(DEPTH):0] count
`endif
);

  localparam int AW = clog2_safe(DEPTH);
  localparam int PW = AW + 1;

  typedef `TYPED_DIM_ENTRY_T(ELEM_W, ELEMS) entry_t;

  // Storage is deliberately not reset; only the pointers carry state that
  // matters after reset.
  entry_t r_mem [DEPTH];

  // The pointer MSB is a lap bit: equal index with differing lap means full.
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;

  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_rd;
  entry_t        w_head;
  logic [ELEMS-1:0] w_nz;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;

  assign w_wr = in_valid && !w_full;
  assign w_rd = out_ready && !w_empty;

  // Empty shows zeros rather than stale storage; no fall-through.
  assign w_head   = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign out_data = w_head;

  typed_dim_nz_reduce #(
    .ELEM_W (ELEM_W),
    .ELEMS  (ELEMS)
  ) u_nz (
    .i_entry (w_head),
    .o_nz    (w_nz)
  );

  assign out_elem_nz = w_nz & {ELEMS{out_valid}};

  // Reset wins over a concurrent write so nothing lands during reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= in_data;
    end
  end

`ifdef TYPED_DIM_FIFO_COUNT_EN
  logic [PW-1:0] r_count;
  assign count = r_count;
`endif

  // Pointers wrap modulo 2*DEPTH through natural PW-bit overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
`ifdef TYPED_DIM_FIFO_COUNT_EN
      r_count <= '0;
`endif
    end else begin
      if (w_wr) r_wptr <= r_wptr + PW'(1);
      if (w_rd) r_rptr <= r_rptr + PW'(1);
`ifdef TYPED_DIM_FIFO_COUNT_EN
      r_count <= r_count + PW'(w_wr) - PW'(w_rd);
`endif
    end
  end

endmodule

// File: tb/tb_typed_dim_fifo.sv
// tb_typed_dim_fifo
//   Directed bench for typed_dim_fifo: the default configuration
//   (6x2, depth 4) and a wide configuration (3x4, depth 8).
//   Expected head values are tracked in exp_q.

module tb_typed_dim_fifo;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance (6x2, depth 4) ----------------
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [1:0]  out_elem_nz;
`ifdef TYPED_DIM_FIFO_COUNT_EN
  logic [2:0]  count;
`endif

  typed_dim_fifo u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_elem_nz (out_elem_nz)
`ifdef TYPED_DIM_FIFO_COUNT_EN
    ,
    .count       (count)
`endif
  );

  // ---------------- wide instance (3x4, depth 8) ----------------
  logic        w_in_valid;
  logic        w_in_ready;
  logic [11:0] w_in_data;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [11:0] w_out_data;
  logic [3:0]  w_out_elem_nz;
`ifdef TYPED_DIM_FIFO_COUNT_EN
  logic [3:0]  w_count;
`endif

  typed_dim_fifo #(
    .ELEM_W (3),
    .ELEMS  (4),
    .DEPTH  (8)
  ) u_wide (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (w_in_valid),
    .in_ready    (w_in_ready),
    .in_data     (w_in_data),
    .out_valid   (w_out_valid),
    .out_ready   (w_out_ready),
    .out_data    (w_out_data),
    .out_elem_nz (w_out_elem_nz)
`ifdef TYPED_DIM_FIFO_COUNT_EN
    ,
    .count       (w_count)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand-derived non-zero flags for the 6x2 layout.
  function automatic logic [1:0] nz2(input logic [11:0] v);
    return {|v[11:6], |v[5:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_data     = '0;
    w_in_valid  = 1'b0;
    w_out_ready = 1'b0;
    w_in_data   = '0;
  endtask

  task automatic push(input logic [11:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [11:0] vals [4];
  logic [11:0] head;
  logic [11:0] nv;

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",  32'(in_ready),    32'd1);
    check("rst_out_valid", 32'(out_valid),   32'd0);
    check("rst_out_data",  32'(out_data),    32'h000);
    check("rst_nz",        32'(out_elem_nz), 32'b00);
`ifdef TYPED_DIM_FIFO_COUNT_EN
    check("rst_count",     32'(count),       32'd0);
`endif

    // Read while empty is ignored
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("empty_rd_valid", 32'(out_valid), 32'd0);

    // Single write, one idle cycle, then inspect head
    push(12'h040);
    tick();
    check("w1_out_valid", 32'(out_valid),   32'd1);
    check("w1_out_data",  32'(out_data),    32'h040);
    check("w1_nz",        32'(out_elem_nz), 32'b10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("w1_drained", 32'(out_valid), 32'd0);
    check("w1_zero",    32'(out_data),  32'h000);

    // Fill to full, drop a fifth write, drain in order
    vals[0] = 12'h03F;
    vals[1] = 12'hFC0;
    vals[2] = 12'h000;
    vals[3] = 12'hABC;
    for (int i = 0; i < 4; i++) begin
      check("fill_in_ready", 32'(in_ready), 32'd1);
      push(vals[i]);
      exp_q.push_back(vals[i]);
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
`ifdef TYPED_DIM_FIFO_COUNT_EN
    check("full_count", 32'(count), 32'd4);
`endif
    push(12'hFFF);
    check("drop_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    check("full_rd_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      head = exp_q.pop_front();
      check("drain_valid", 32'(out_valid),   32'd1);
      check("drain_data",  32'(out_data),    32'(head));
      check("drain_nz",    32'(out_elem_nz), 32'(nz2(head)));
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_ready", 32'(in_ready),  32'd1);

    // Fill to 3, then 10 cycles of simultaneous read/write
    for (int i = 0; i < 3; i++) begin
      nv = 12'h100 + 12'(i * 17);
      push(nv);
      exp_q.push_back(nv);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nv = 12'h500 + 12'(i * 33);
      in_data = nv;
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_ready", 32'(in_ready),  32'd1);
      check("stream_data",  32'(out_data),  32'(exp_q[0]));
`ifdef TYPED_DIM_FIFO_COUNT_EN
      check("stream_count", 32'(count), 32'd3);
`endif
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(nv);
    end
    check("stream_post_data", 32'(out_data), 32'(exp_q[0]));

    // Reset with 3 entries while both sides request
    in_data = 12'h777;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    check("mrst_out_valid", 32'(out_valid),   32'd0);
    check("mrst_in_ready",  32'(in_ready),    32'd1);
    check("mrst_out_data",  32'(out_data),    32'h000);
    check("mrst_nz",        32'(out_elem_nz), 32'b00);
`ifdef TYPED_DIM_FIFO_COUNT_EN
    check("mrst_count",     32'(count),       32'd0);
`endif
    push(12'h123);
    check("post_rst_data", 32'(out_data),    32'h123);
    check("post_rst_nz",   32'(out_elem_nz), 32'b11);

    // Wide configuration: 3-bit x 4 elements, depth 8
    w_in_valid = 1'b1;
    w_in_data  = 12'h801;
    tick();
    check("wide_data", 32'(w_out_data),    32'h801);
    check("wide_nz",   32'(w_out_elem_nz), 32'b1001);
    for (int i = 1; i < 8; i++) begin
      check("wide_fill_ready", 32'(w_in_ready), 32'd1);
      w_in_data = 12'(i);
      tick();
    end
    w_in_valid = 1'b0;
    check("wide_full",      32'(w_in_ready), 32'd0);
    check("wide_head_keep", 32'(w_out_data), 32'h801);
`ifdef TYPED_DIM_FIFO_COUNT_EN
    check("wide_count",     32'(w_count),    32'd8);
`endif
    w_out_ready = 1'b1;
    tick();
    w_out_ready = 1'b0;
    check("wide_second",    32'(w_out_data),    32'h001);
    check("wide_second_nz", 32'(w_out_elem_nz), 32'b0001);
    check("wide_ready",     32'(w_in_ready),    32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/typed_dim_fifo.md
TYPED_DIM_FIFO -- requirements
Module: typed_dim_fifo

Interface
REQ-001 SHALL have parameter ELEM_W, default 6, bit width of one element of the packed entry type.
REQ-002 SHALL have parameter ELEMS, default 2, number of elements per entry; entry width = ELEMS*ELEM_W.
REQ-003 SHALL have parameter DEPTH, default 4, entry count; a power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, write request.
REQ-007 SHALL have port in_ready, output, 1, not full.
REQ-008 SHALL have port in_data, input, ELEMS*ELEM_W, packed entry, element 0 in the LSBs.
REQ-009 SHALL have port out_valid, output, 1, not empty.
REQ-010 SHALL have port out_ready, input, 1, read acknowledge.
REQ-011 SHALL have port out_data, output, ELEMS*ELEM_W, head entry.
REQ-012 SHALL have port out_elem_nz, output, ELEMS, one bit per head element; the bit is 1 when that element is non-zero.

Function
REQ-013 Storage SHALL be DEPTH entries of the package entry typedef, with write and read pointers of log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
REQ-014 Write accepted when in_valid and in_ready; read accepted when out_valid and out_ready; each accepted transfer advances its pointer by 1 and wraps modulo 2*DEPTH.
REQ-015 Status decode:
  - empty: pointers equal.
  - full: index bits equal and MSBs differ.
  - in_ready = !full.
  - out_valid = !empty.
REQ-016 out_data SHALL be the entry at the read index, driven combinationally from storage; write-to-read latency is 1 cycle (data written at edge N is visible after edge N).
REQ-017 out_elem_nz[k] SHALL be the OR-reduction of element k of out_data, gated by out_valid.
REQ-018 When empty, out_data SHALL be all zeros and out_elem_nz SHALL be 0; there is no fall-through in the same cycle.
REQ-019 Simultaneous accepted read and write when neither full nor empty SHALL leave occupancy unchanged.
REQ-020 When full with out_ready=1, in_ready SHALL stay 0 that cycle, i.e. in_ready does not depend on out_ready.
REQ-021 Write attempts while full and read attempts while empty SHALL be ignored; no pointer or storage change.
REQ-022 Storage contents SHALL NOT be reset; only pointers and flags are reset.

Reset
REQ-023 rst=1 at an edge SHALL clear both pointers. After that edge:
  - in_ready=1, out_valid=0, out_data=0, out_elem_nz=0.
REQ-024 Reset mid-operation SHALL discard all stored entries and take priority over any concurrent transfer in that cycle.

Configuration
REQ-025 With TYPED_DIM_FIFO_COUNT_EN defined, the block SHALL add output count, width log2(DEPTH)+1, equal to write pointer minus read pointer and registered with the pointers (reset 0, max DEPTH).
REQ-026 Without TYPED_DIM_FIFO_COUNT_EN, the count port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package typed_dim_pkg SHALL hold:
  - the function clog2_safe;
  - the parametrised element typedef (logic [ELEM_W-1:0]);
  - the entry typedef, a packed array [ELEMS-1:0] of elements, declared via a parametrised class or typedef macro so that its dimensions follow the parameters.
REQ-028 Sub-module typed_dim_nz_reduce SHALL compute the per-element non-zero vector from an entry; it is purely combinational and instantiated once.

Verification
REQ-029 Reset with defaults -> in_ready=1, out_valid=0, out_data=12'h000, out_elem_nz=2'b00.
REQ-030 Write 12'h040 (element1=1, element0=0), then one idle cycle -> out_valid=1, out_data=12'h040, out_elem_nz=2'b10.
REQ-031 Four writes with no reads at DEPTH=4 -> in_ready=0 after the 4th edge; a 5th write is dropped; four reads return the first four values in order, then out_valid=0.
REQ-032 Fill to 3 entries, then hold in_valid=out_ready=1 for 10 cycles -> occupancy stays 3 (count=3 with the macro), output order is preserved, and both pointers wrap past 2*DEPTH correctly.
REQ-033 Assert rst with 3 entries while in_valid=out_ready=1 -> next cycle out_valid=0, in_ready=1, count=0, and no transfer is counted.
REQ-034 ELEM_W=3, ELEMS=4, DEPTH=8: write 12'h801 -> out_elem_nz=4'b1001 and full asserts after 8 writes.
